// File: rtl/display_scan_if.sv
// Digit/blink/dp inputs and multiplexed display outputs of the 7-segment scan controller.
// master drives the digit data, slave is the scan controller.
interface display_scan_if #(
  parameter int unsigned NumDigits = 8
) ();
  logic                   en;
  logic [4*NumDigits-1:0] digits;
  logic [NumDigits-1:0]   blink_mask;
  logic [NumDigits-1:0]   dp_in;
  logic                   lz_blank;
  logic [NumDigits-1:0]   an;
  logic [6:0]             seg;
  logic                   dp_out;
  logic                   blink_phase;
  logic                   frame_start;

  modport master (
    output en, digits, blink_mask, dp_in, lz_blank,
    input  an, seg, dp_out, blink_phase, frame_start
  );

  modport slave (
    input  en, digits, blink_mask, dp_in, lz_blank,
    output an, seg, dp_out, blink_phase, frame_start
  );
endinterface

// File: rtl/display_scan_ctrl.sv
// Multiplexed 7-segment scan driver: per-frame input snapshot, blink, leading-zero blanking,
// anode dead time and registered (1-cycle latency) anode/segment outputs.
module display_scan_ctrl #(
  parameter int unsigned NumDigits    = 8,
  parameter int unsigned ClkHz        = 50_000_000,
  parameter int unsigned ScanHz       = 1000,
  parameter int unsigned BlinkHz      = 2,
  parameter int unsigned DeadCycles   = 2,
  parameter bit          AnActiveLow  = 1'b1,
  parameter bit          SegActiveLow = 1'b1
) (
  input  logic          clk,
  input  logic          rst_n,
  display_scan_if.slave bus
);
  localparam int unsigned ScanDiv  = ClkHz / ScanHz;
  localparam int unsigned BlinkDiv = ClkHz / (2 * BlinkHz);
  localparam int unsigned DivW     = $clog2(ScanDiv);
  localparam int unsigned BlinkW   = (BlinkDiv > 1) ? $clog2(BlinkDiv) : 1;
  localparam int unsigned IdxW     = $clog2(NumDigits);

  localparam logic [DivW-1:0]      DivLast   = DivW'(ScanDiv - 1);
  localparam logic [DivW-1:0]      DeadEnd   = DivW'(DeadCycles);
  localparam logic [BlinkW-1:0]    BlinkLast = BlinkW'(BlinkDiv - 1);
  localparam logic [IdxW-1:0]      IdxLast   = IdxW'(NumDigits - 1);
  localparam logic [NumDigits-1:0] AnOff     = {NumDigits{AnActiveLow}};
  localparam logic [6:0]           SegOff    = {7{SegActiveLow}};

  logic [DivW-1:0]             div_cnt_q, div_cnt_d;
  logic [IdxW-1:0]             idx_q, idx_d;
  logic [BlinkW-1:0]           blink_cnt_q, blink_cnt_d;
  logic                        blink_q, blink_d;
  logic                        primed_q, primed_d;
  logic                        frame_q, frame_d;
  logic [NumDigits-1:0][3:0]   snap_dig_q, snap_dig_d;
  logic [NumDigits-1:0]        snap_mask_q, snap_mask_d;
  logic [NumDigits-1:0]        snap_dp_q, snap_dp_d;
  logic                        snap_lz_q, snap_lz_d;
  logic [NumDigits-1:0]        an_q, an_d;
  logic [6:0]                  seg_q, seg_d;
  logic                        dp_q, dp_d;

  logic [NumDigits-1:0]        lz_vec;
  logic                        tail_zero;
  logic [3:0]                  cur_code;
  logic                        blink_off;
  logic [NumDigits-1:0]        an_act;
  logic [6:0]                  seg_act;
  logic                        dp_act;

  function automatic logic [6:0] decode(input logic [3:0] code);
    logic [6:0] s;
    unique case (code)
      4'h0: s = 7'h3F;
      4'h1: s = 7'h06;
      4'h2: s = 7'h5B;
      4'h3: s = 7'h4F;
      4'h4: s = 7'h66;
      4'h5: s = 7'h6D;
      4'h6: s = 7'h7D;
      4'h7: s = 7'h07;
      4'h8: s = 7'h7F;
      4'h9: s = 7'h6F;
      4'hA: s = 7'h77;
      4'hB: s = 7'h7C;
      4'hC: s = 7'h39;
      4'hD: s = 7'h5E;
      4'hE: s = 7'h79;
      4'hF: s = 7'h00;
    endcase
    return s;
  endfunction

  always_comb begin
    blink_cnt_d = blink_cnt_q + 1'b1;
    blink_d     = blink_q;
    if (blink_cnt_q == BlinkLast) begin
      blink_cnt_d = '0;
      blink_d     = ~blink_q;
    end

    div_cnt_d   = '0;
    idx_d       = '0;
    primed_d    = 1'b0;
    frame_d     = 1'b0;
    snap_dig_d  = snap_dig_q;
    snap_mask_d = snap_mask_q;
    snap_dp_d   = snap_dp_q;
    snap_lz_d   = snap_lz_q;
    if (bus.en) begin
      primed_d = 1'b1;
      // A new frame starts on the first enabled cycle or when the last dwell of a frame ends.
      frame_d  = ~primed_q | ((idx_q == IdxLast) && (div_cnt_q == DivLast));
      if (div_cnt_q == DivLast) begin
        div_cnt_d = '0;
        idx_d     = (idx_q == IdxLast) ? '0 : idx_q + 1'b1;
      end else begin
        div_cnt_d = div_cnt_q + 1'b1;
        idx_d     = idx_q;
      end
      if (frame_d) begin
        snap_dig_d  = bus.digits;
        snap_mask_d = bus.blink_mask;
        snap_dp_d   = bus.dp_in;
        snap_lz_d   = bus.lz_blank;
      end
    end
  end

  always_comb begin
    lz_vec    = '0;
    tail_zero = 1'b1;
    for (int i = NumDigits - 1; i >= 1; i--) begin
      tail_zero = tail_zero & ((snap_dig_q[i] == 4'h0) || (snap_dig_q[i] == 4'hF));
      lz_vec[i] = snap_lz_q & tail_zero;
    end
  end

  always_comb begin
    an_act    = '0;
    seg_act   = '0;
    dp_act    = 1'b0;
    cur_code  = snap_dig_q[idx_q];
    blink_off = snap_mask_q[idx_q] & blink_q;
    if (bus.en) begin
      if (!((cur_code == 4'hF) || blink_off || lz_vec[idx_q])) begin
        seg_act = decode(cur_code);
      end
      dp_act = snap_dp_q[idx_q] & ~blink_off;
      if (div_cnt_q >= DeadEnd) begin
        an_act[idx_q] = 1'b1;
      end
    end
    an_d  = AnActiveLow ? ~an_act : an_act;
    seg_d = SegActiveLow ? ~seg_act : seg_act;
    dp_d  = SegActiveLow ? ~dp_act : dp_act;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      div_cnt_q   <= '0;
      idx_q       <= '0;
      blink_cnt_q <= '0;
      blink_q     <= 1'b0;
      primed_q    <= 1'b0;
      frame_q     <= 1'b0;
      snap_dig_q  <= {NumDigits{4'hF}};
      snap_mask_q <= '0;
      snap_dp_q   <= '0;
      snap_lz_q   <= 1'b0;
      an_q        <= AnOff;
      seg_q       <= SegOff;
      dp_q        <= SegActiveLow;
    end else begin
      div_cnt_q   <= div_cnt_d;
      idx_q       <= idx_d;
      blink_cnt_q <= blink_cnt_d;
      blink_q     <= blink_d;
      primed_q    <= primed_d;
      frame_q     <= frame_d;
      snap_dig_q  <= snap_dig_d;
      snap_mask_q <= snap_mask_d;
      snap_dp_q   <= snap_dp_d;
      snap_lz_q   <= snap_lz_d;
      an_q        <= an_d;
      seg_q       <= seg_d;
      dp_q        <= dp_d;
    end
  end

  assign bus.an          = an_q;
  assign bus.seg         = seg_q;
  assign bus.dp_out      = dp_q;
  assign bus.blink_phase = blink_q;
  assign bus.frame_start = frame_q;
endmodule

// File: tb/tb_display_scan_ctrl.sv
// Scoreboarded random/directed bench for display_scan_ctrl; the reference model works from
// elapsed-cycle arithmetic (time since reset / since enable) and a per-frame input snapshot.
module tb_display_scan_ctrl;
  localparam int N        = 8;
  localparam int ScanDiv  = 10;
  localparam int BlinkDiv = 50;
  localparam int Dead     = 2;
  localparam int Frame    = ScanDiv * N;

  typedef struct {
    logic [7:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       ph;
    logic       fs;
    bit         chk_seg;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  display_scan_if #(.NumDigits(N)) bus ();

  display_scan_ctrl #(
    .NumDigits   (N),
    .ClkHz       (100),
    .ScanHz      (10),
    .BlinkHz     (1),
    .DeadCycles  (Dead),
    .AnActiveLow (1'b1),
    .SegActiveLow(1'b1)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  exp_t       q[$];
  int         checks = 0;
  int         errors = 0;
  int         cyc    = 0;
  // Model state: edges since reset, edges since the first enabled edge (-1 = not scanning).
  int         m      = 0;
  int         n      = -1;
  logic [3:0] sd [N];
  logic [N-1:0] sm, sdp;
  logic       slz;

  function automatic logic [6:0] glyph(input logic [3:0] code);
    case (code)
      4'h0: return 7'b0111111;
      4'h1: return 7'b0000110;
      4'h2: return 7'b1011011;
      4'h3: return 7'b1001111;
      4'h4: return 7'b1100110;
      4'h5: return 7'b1101101;
      4'h6: return 7'b1111101;
      4'h7: return 7'b0000111;
      4'h8: return 7'b1111111;
      4'h9: return 7'b1101111;
      4'hA: return 7'b1110111;
      4'hB: return 7'b1111100;
      4'hC: return 7'b0111001;
      4'hD: return 7'b1011110;
      4'hE: return 7'b1111001;
      default: return 7'b0000000;
    endcase
  endfunction

  function automatic bit leading_zero(input int idx);
    if (!slz || idx == 0) return 1'b0;
    for (int j = idx; j < N; j++) begin
      if (sd[j] != 4'h0 && sd[j] != 4'hF) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  // One clock edge: model the edge with the inputs held across it, queue the expected outputs.
  task automatic step();
    exp_t e;
    int   c, idx, m_old;
    bit   bl, blanked;
    @(posedge clk);
    cyc++;
    e.an = 8'hFF; e.seg = 7'h7F; e.dp = 1'b1; e.ph = 1'b0; e.fs = 1'b0; e.chk_seg = 1'b1;
    if (!rst_n) begin
      m = 0;
      n = -1;
      for (int i = 0; i < N; i++) sd[i] = 4'hF;
      sm  = '0;
      sdp = '0;
      slz = 1'b0;
    end else begin
      m_old = m;
      m     = m + 1;
      bl    = ((m_old / BlinkDiv) % 2) == 1;
      e.ph  = ((m / BlinkDiv) % 2) == 1;
      if (bus.en) begin
        n    = (n < 0) ? 0 : n + 1;
        c    = n % Frame;
        idx  = c / ScanDiv;
        e.fs = (n == 0) || (c == Frame - 1);
        if ((c % ScanDiv) >= Dead) begin
          e.an    = ~(8'd1 << idx);
          blanked = (sd[idx] == 4'hF) || (sm[idx] && bl) || leading_zero(idx);
          e.seg   = blanked ? 7'h7F : ~glyph(sd[idx]);
          e.dp    = ~(sdp[idx] && !(sm[idx] && bl));
        end else begin
          e.chk_seg = 1'b0;
        end
        if (e.fs) begin
          for (int i = 0; i < N; i++) sd[i] = bus.digits[4*i +: 4];
          sm  = bus.blink_mask;
          sdp = bus.dp_in;
          slz = bus.lz_blank;
        end
      end else begin
        n = -1;
      end
    end
    q.push_back(e);
    #1;
  endtask

  task automatic run(input int k);
    for (int i = 0; i < k; i++) step();
  endtask

  // Bounded advance to a point inside the dwell of digit 'target' (model time only).
  task automatic run_to_idx(input int target);
    for (int k = 0; k < 2 * Frame; k++) begin
      if (n >= 0 && ((n % Frame) / ScanDiv) == target && (n % ScanDiv) == 4) return;
      step();
    end
  endtask

  function automatic logic [31:0] rand_digits();
    logic [31:0] d;
    for (int i = 0; i < N; i++) begin
      case ($urandom_range(0, 3))
        0:       d[4*i +: 4] = 4'h0;
        1:       d[4*i +: 4] = 4'hF;
        default: d[4*i +: 4] = 4'($urandom_range(0, 15));
      endcase
    end
    return d;
  endfunction

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        check("an", 32'(bus.an), 32'(e.an));
        check("blink_phase", 32'(bus.blink_phase), 32'(e.ph));
        check("frame_start", 32'(bus.frame_start), 32'(e.fs));
        if (e.chk_seg) begin
          check("seg", 32'(bus.seg), 32'(e.seg));
          check("dp_out", 32'(bus.dp_out), 32'(e.dp));
        end
      end
    end
  end

  initial begin : stimulus
    int r;
    bus.en = 1'b0; bus.digits = 32'hFF123456; bus.blink_mask = '0;
    bus.dp_in = '0; bus.lz_blank = 1'b0;
    rst_n = 1'b0;
    run(2);
    rst_n = 1'b1; bus.en = 1'b1; bus.dp_in = 8'h04;
    run(2 * Frame + 10);

    run_to_idx(3);
    bus.digits = rand_digits(); bus.dp_in = 8'($urandom);
    run(2 * Frame);

    bus.digits = 32'h00001259; bus.blink_mask = 8'h03; bus.dp_in = 8'h01;
    run(250);

    bus.blink_mask = '0; bus.dp_in = '0; bus.lz_blank = 1'b1;
    bus.digits = 32'h00000400;
    run(2 * Frame + 5);
    bus.digits = 32'h00000000;
    run(2 * Frame + 5);
    bus.lz_blank = 1'b0;

    bus.digits = rand_digits();
    run_to_idx(5);
    bus.en = 1'b0;
    run(7);
    bus.en = 1'b1;
    run(Frame + 20);

    run(13);
    rst_n = 1'b0;
    run(1);
    rst_n = 1'b1;
    run(Frame + 20);

    for (int k = 0; k < 1500; k++) begin
      r = $urandom_range(0, 999);
      rst_n = (r >= 3);
      if (bus.en && r >= 3 && r < 8) bus.en = 1'b0;
      else if (!bus.en && r >= 100 && r < 200) bus.en = 1'b1;
      if (r >= 10 && r < 60) begin
        bus.digits     = rand_digits();
        bus.blink_mask = 8'($urandom);
        bus.dp_in      = 8'($urandom);
        bus.lz_blank   = 1'($urandom);
      end
      step();
    end

    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
